// File: rtl/addsub_simd_pipe.sv
// Two-stage SIMD adder/subtractor: 4, 2 or 1 lanes selected per beat, valid/ready on both sides.
// Define ADDSUB_SAT_EN to enable per-lane signed saturation requested by in_sat.
module addsub_simd_pipe #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned WIDTH  = 4 * LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [1:0]       in_mode,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic [3:0]       out_cout,
  output logic [3:0]       out_ovf
);

  if (WIDTH != 4 * LANE_W) begin : g_width_check
    $error("addsub_simd_pipe: WIDTH must equal 4*LANE_W");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_sub_q, s1_sub_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_s_q, s2_s_d;
  logic [3:0]       s2_cout_q, s2_cout_d;
  logic [3:0]       s2_ovf_q, s2_ovf_d;

  logic             s1_load, s2_load;
  logic [3:0]       lane_start, lane_msb;
  logic [WIDTH-1:0] raw_s, res_s;
  logic [3:0]       cout_c, ovf_c;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Chunk c is a lane MSB when it is the top chunk or chunk c+1 starts a new lane.
  always_comb begin
    lane_start = 4'b1111;
    unique case (s1_mode_q)
      2'b01:   lane_start = 4'b0101;
      2'b10:   lane_start = 4'b0001;
      default: lane_start = 4'b1111;
    endcase
    lane_msb = {1'b1, lane_start[3:1]};
  end

  always_comb begin
    logic [LANE_W-1:0] a_ch, bx_ch;
    logic [LANE_W:0]   ch_sum;
    logic              carry, cin;
    raw_s  = '0;
    cout_c = '0;
    ovf_c  = '0;
    carry  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      a_ch   = s1_a_q[c*LANE_W +: LANE_W];
      bx_ch  = s1_b_q[c*LANE_W +: LANE_W] ^ {LANE_W{s1_sub_q}};
      cin    = lane_start[c] ? s1_sub_q : carry;
      ch_sum = {1'b0, a_ch} + {1'b0, bx_ch} + {{LANE_W{1'b0}}, cin};
      carry  = ch_sum[LANE_W];
      raw_s[c*LANE_W +: LANE_W] = ch_sum[LANE_W-1:0];
      if (lane_msb[c]) begin
        cout_c[c] = carry;
        ovf_c[c]  = (a_ch[LANE_W-1] == bx_ch[LANE_W-1]) && (ch_sum[LANE_W-1] != a_ch[LANE_W-1]);
      end
    end
  end

`ifdef ADDSUB_SAT_EN
  logic s1_sat_q, s1_sat_d;

  // Walk chunks top-down so each chunk inherits the clamp decision of its lane's MSB chunk.
  always_comb begin
    logic clamp, neg;
    res_s = raw_s;
    clamp = 1'b0;
    neg   = 1'b0;
    for (int c = 3; c >= 0; c--) begin
      if (lane_msb[c]) begin
        clamp = s1_sat_q && ovf_c[c];
        neg   = s1_a_q[c*LANE_W + LANE_W - 1];
      end
      if (clamp) begin
        if (lane_msb[c]) begin
          res_s[c*LANE_W +: LANE_W] = neg ? {1'b1, {(LANE_W-1){1'b0}}}
                                          : {1'b0, {(LANE_W-1){1'b1}}};
        end else begin
          res_s[c*LANE_W +: LANE_W] = {LANE_W{~neg}};
        end
      end
    end
  end

  always_comb begin
    s1_sat_d = s1_sat_q;
    if (s1_load && in_valid) s1_sat_d = in_sat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) s1_sat_q <= 1'b0;
    else        s1_sat_q <= s1_sat_d;
  end
`else
  logic unused_sat;
  assign unused_sat = in_sat;
  assign res_s      = raw_s;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sub_d   = s1_sub_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_s_d     = s2_s_q;
    s2_cout_d  = s2_cout_q;
    s2_ovf_d   = s2_ovf_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = in_a;
        s1_b_d    = in_b;
        s1_sub_d  = in_sub;
        s1_mode_d = in_mode;
      end
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_s_d    = res_s;
        s2_cout_d = cout_c;
        s2_ovf_d  = ovf_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sub_q   <= 1'b0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_s_q     <= '0;
      s2_cout_q  <= '0;
      s2_ovf_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sub_q   <= s1_sub_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_s_q     <= s2_s_d;
      s2_cout_q  <= s2_cout_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_s     = s2_s_q;
  assign out_cout  = s2_cout_q;
  assign out_ovf   = s2_ovf_q;

endmodule

// File: tb/tb_addsub_simd_pipe.sv
// Scoreboard bench for addsub_simd_pipe: lane arithmetic modelled with plain integer maths.
module tb_addsub_simd_pipe;
  localparam int Width = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [Width-1:0]  in_a = '0;
  logic [Width-1:0]  in_b = '0;
  logic              in_sub = 1'b0;
  logic [1:0]        in_mode = '0;
  logic              in_sat = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [Width-1:0]  out_s;
  logic [3:0]        out_cout;
  logic [3:0]        out_ovf;

  addsub_simd_pipe #(.LANE_W(8), .WIDTH(Width)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_mode   (in_mode),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic [3:0]  cout;
    logic [3:0]  ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic stalled_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Lane-level reference: exact integer sum/difference, range test for overflow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 input logic [1:0] mode, input logic sat);
    exp_t   e;
    int     w, top;
    longint mask, half, ua, ub, sa, sb, full, ex, res;
    e    = '0;
    w    = (mode == 2'b01) ? 16 : ((mode == 2'b10) ? 32 : 8);
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    for (int k = 0; k < Width / w; k++) begin
      ua   = longint'({32'b0, a >> (k * w)}) & mask;
      ub   = longint'({32'b0, b >> (k * w)}) & mask;
      sa   = (ua >= half) ? ua - (mask + 1) : ua;
      sb   = (ub >= half) ? ub - (mask + 1) : ub;
      full = sub ? ua + (mask + 1) - ub : ua + ub;
      ex   = sub ? sa - sb : sa + sb;
      res  = full & mask;
      top  = (k + 1) * (w / 8) - 1;
      e.cout[top] = full[w];
      e.ovf[top]  = (ex > half - 1) || (ex < -half);
`ifdef ADDSUB_SAT_EN
      if (sat && e.ovf[top]) res = (ex > 0) ? half - 1 : half;
`else
      if (sat) res = res;
`endif
      e.s = e.s | 32'(res << (k * w));
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [1:0] mode, input logic sat);
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_mode = mode;
    in_sat = sat;
    @(negedge clk);
    if (!in_ready) stalled_seen = 1'b1;
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      exp_q.push_back(model(a, b, sub, mode, sat));
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one beat on an empty pipe and check the 2-cycle latency.
  task automatic send_lat(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [1:0] mode, input logic sat);
    send(a, b, sub, mode, sat);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_not_early", out_valid, 1'b0);
    @(negedge clk);
    chk("latency_2_cycles", out_valid, 1'b1);
    idle(2);
  endtask

  // Monitor: pops on every output handshake and checks stability while stalled.
  logic        hold_pend = 1'b0;
  logic [31:0] held_s;
  logic [3:0]  held_cout, held_ovf;
  exp_t        got_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_s", out_s, held_s);
        chk("hold_cout_ovf", {out_cout, out_ovf}, {held_cout, held_ovf});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_valid, 1'b0);
        end else begin
          got_e = exp_q.pop_front();
          chk("out_s", out_s, got_e.s);
          chk("out_cout", out_cout, got_e.cout);
          chk("out_ovf", out_ovf, got_e.ovf);
        end
      end
      hold_pend = out_valid && !out_ready;
      held_s    = out_s;
      held_cout = out_cout;
      held_ovf  = out_ovf;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    bit done;
    // Reset held with in_valid asserted.
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_a = 32'h1234_5678;
    in_b = 32'h0000_0001;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_s", out_s, 32'h0);
      chk("rst_cout_ovf", {out_cout, out_ovf}, 8'h00);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    idle(1);

    // Directed arithmetic beats.
    send_lat(32'h01FF_7F80, 32'h0101_8080, 1'b0, 2'b00, 1'b0);
    send_lat(32'h0000_0000, 32'h0000_0001, 1'b1, 2'b10, 1'b0);
    send_lat(32'h0000_0000, 32'h0000_0001, 1'b1, 2'b01, 1'b0);
    send_lat(32'h8000_0000, 32'h8000_0000, 1'b0, 2'b11, 1'b0);
    send_lat(32'h7F80_7F80, 32'h0101_0000, 1'b0, 2'b00, 1'b1);
    send_lat(32'h7F80_7F80, 32'h0001_0000, 1'b1, 2'b00, 1'b1);
    send_lat(32'h7FFF_8000, 32'h0001_0001, 1'b1, 2'b01, 1'b1);

    // Back-pressure: six beats, consumer stalls for four cycles.
    stalled_seen = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    for (int k = 1; k <= 6; k++) send(32'(k), 32'h1, 1'b0, 2'b10, 1'b0);
    idle(10);
    chk("bp_in_ready_low", stalled_seen, 1'b1);
    chk("bp_all_delivered", 64'(exp_q.size()), 64'd0);

    // Random traffic with random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
          end
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
        end
        idle(1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(10);
    chk("rand_all_delivered", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight: they must vanish.
    out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 2'b00, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 1'b1, 2'b01, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 1'b0);
    end
    send(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 2'b10, 1'b0);
    idle(6);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
